mc_sequencer: RTL and testbench
===============================

// Module: mc_sequencer
// PURPOSE
//  Multi-cycle sequencer for the next-generation datapath. It replaces the free-running
//  single-cycle PC and branch glue with a FETCH/DECODE/EXEC/MEM/WB FSM that owns PC and IR.
//  It talks to variable-latency instruction/data memories over req/ack, and gates
//  register-file and memory enables from the existing ControlUnit outputs.
//  Adds halt, ack timeout fault, and saturating cycle/retire counters.
// PARAMETERS
//  XLEN      32  address/PC width (>=16)
//  PC_RESET  0   PC value after reset
//  TIMEOUT   16  max cycles waiting for ack before FAULT; 0 disables timeout
//  CNT_W     32  width of perf counters
// PORTS
//  clk         in   1     single clock, rising edge
//  arst_n      in   1     asynchronous active-low reset
//  imem_req    out  1     instruction fetch request
//  imem_addr   out  XLEN  fetch address (=pc)
//  imem_ack    in   1     fetch done; imem_rdata valid this cycle
//  imem_rdata  in   32    instruction word
//  dmem_req    out  1     data access request
//  dmem_we     out  1     1=store, 0=load; valid while dmem_req
//  dmem_ack    in   1     data access done
//  cu_mem_read in   1     ControlUnit MemRead for current IR
//  cu_mem_write in  1     ControlUnit MemWrite
//  cu_reg_write in  1     ControlUnit RegWrite
//  cu_br_eq/cu_br_ne/cu_br_tz in 1 each  ControlUnit branch types
//  alu_zero    in   1     ALU ze flag
//  alu_cout    in   1     ALU cout flag
//  ir          out  32    instruction register
//  pc          out  XLEN  program counter
//  reg_we      out  1     register-file write strobe, one cycle in WB
//  retire      out  1     one-cycle pulse per completed instruction
//  state       out  3     current FSM state (debug)
//  halted/fault out 1 each  sticky status
//  cyc_cnt/ret_cnt out CNT_W each  perf counters
// BEHAVIOUR
//  Reset (async, arst_n=0): state=FETCH. pc=PC_RESET. ir=0. All strobes/req=0.
//   halted=fault=0. Counters=0. imem_req drops immediately, not at the next edge.
//  FETCH: imem_req=1, addr stable until an ack is sampled. On imem_ack: ir<=imem_rdata,
//   go to DECODE. An ack without a req is ignored in every state.
//  DECODE (1 cycle): if ir[31:26]==6'h3F, go to HALTED. Else go to EXEC.
//  EXEC (1 cycle): taken = (br_eq&zero)|(br_ne&~zero)|(br_tz&~cout&~zero).
//   - Branch: pc <= pc+4+(sext(ir[15:0])<<2) if taken, else pc+4.
//     Then go to FETCH with a retire pulse.
//   - Memory op: go to MEM.
//   - Else if cu_reg_write: go to WB.
//   - Else: pc+=4, retire, go to FETCH.
//   - If cu_mem_read and cu_mem_write are both set, the op is treated as a store.
//  MEM: dmem_req=1, dmem_we=cu_mem_write. On dmem_ack: a load goes to WB;
//   a store does pc+=4, retire, FETCH.
//  WB (1 cycle): reg_we=1, pc+=4, retire, go to FETCH.
//  Latency with zero-wait acks: ALU op 4 cycles, load 5, store 4, branch 3.
//  Timeout: a wait counter clears on entry to FETCH/MEM and increments each cycle
//   without ack. When it reaches TIMEOUT with no ack, go to FAULT and set fault=1.
//   An ack in the same cycle the counter hits TIMEOUT wins, so no fault is raised.
//  HALTED/FAULT: terminal until reset. No req, no strobes, pc/ir frozen.
//  PC arithmetic is modulo 2^XLEN; wrap-around is silent.
//  cyc_cnt increments every cycle outside HALTED/FAULT. ret_cnt increments on retire.
//   Both saturate at all-ones.
//  Reset mid-transaction abandons it; the memory must tolerate req dropping before ack.
// STRUCTURE
//  Shared header mc_defs.vh: state encodings FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4,
//   HALTED=5, FAULT=6; OP_HALT=6'h3F.
//  One sub-module mc_ack_timer (parametrised TIMEOUT): clear/tick inputs, expired output.
//  Branch evaluation and next-PC logic stay inline.
// TESTING
//  1 Reset: arst_n low mid-MEM -> dmem_req=0 same cycle; pc=PC_RESET, state=FETCH after release.
//  2 ALU op, ack in 1st req cycle: reg_we pulses in cycle 4, pc 0->4, ret_cnt=1, cyc_cnt=4.
//  3 BEQ imm=0xFFFF, zero=1 at pc=8 -> pc=8; same with zero=0 -> pc=12; no reg_we.
//  4 Load with dmem_ack delayed 3 cycles, TIMEOUT=16 -> WB reached, no fault, 8 cycles total.
//  5 imem_ack never asserted, TIMEOUT=4 -> fault=1 after 4 wait cycles; cyc_cnt then frozen.
//  6 Fetch 0xFC000000 -> halted=1 after DECODE; no further req; CNT_W=4 check: ret_cnt sticks at 15.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
// Shared state encoding, opcode constants and branch rule for the multi-cycle sequencer.
package mc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [5:0] OP_HALT = 6'h3F;

    function automatic logic branch_taken(
        input logic br_eq,
        input logic br_ne,
        input logic br_tz,
        input logic zero,
        input logic cout
    );
        return (br_eq & zero) | (br_ne & ~zero) | (br_tz & ~cout & ~zero);
    endfunction

endpackage

// File: rtl/mc_ack_timer.sv
// Counts consecutive cycles spent waiting for a memory ack; flags the TIMEOUT-th one.
module mc_ack_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_timer_inputs;
            assign unused_timer_inputs = &{1'b0, clk, arst_n, clear, tick};
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
            logic [CW-1:0] count_reg;

            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (tick) begin
                    count_reg <= count_reg + CW'(1);
                end
            end

            // Fires during the TIMEOUT-th ack-less cycle; an ack that cycle suppresses tick.
            assign expired = tick && (count_reg == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mc_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR, with halt, ack timeout and perf counters.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  PC_RESET = '0,
    parameter int               TIMEOUT  = 16,
    parameter int               CNT_W    = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             cu_mem_read,
    input  logic             cu_mem_write,
    input  logic             cu_reg_write,
    input  logic             cu_br_eq,
    input  logic             cu_br_ne,
    input  logic             cu_br_tz,
    input  logic             alu_zero,
    input  logic             alu_cout,
    output logic [31:0]      ir,
    output logic [XLEN-1:0]  pc,
    output logic             reg_we,
    output logic             retire,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    state_t           state_reg, state_next;
    logic [XLEN-1:0]  pc_reg, pc_next;
    logic [31:0]      ir_reg, ir_next;
    logic [CNT_W-1:0] cyc_reg, ret_reg;
    logic             fetch_active, mem_active, reg_we_c, retire_c;
    logic             wait_state, ack_now, expired;
    logic [XLEN-1:0]  pc_plus4, br_off;
    logic             is_branch;

    assign pc_plus4  = pc_reg + XLEN'(4);
    assign br_off    = XLEN'($signed({ir_reg[15:0], 2'b00}));
    assign is_branch = cu_br_eq | cu_br_ne | cu_br_tz;

    assign wait_state = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
    assign ack_now    = (state_reg == ST_FETCH) ? imem_ack : dmem_ack;

    mc_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .arst_n  (arst_n),
        .clear   (~wait_state | ack_now),
        .tick    (wait_state & ~ack_now),
        .expired (expired)
    );

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        fetch_active = 1'b0;
        mem_active   = 1'b0;
        reg_we_c     = 1'b0;
        retire_c     = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                fetch_active = 1'b1;
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    state_next = ST_DECODE;
                end else if (expired) begin
                    state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_next = (ir_reg[31:26] == OP_HALT) ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                if (is_branch) begin
                    pc_next    = branch_taken(cu_br_eq, cu_br_ne, cu_br_tz, alu_zero, alu_cout)
                               ? pc_plus4 + br_off : pc_plus4;
                    retire_c   = 1'b1;
                    state_next = ST_FETCH;
                end else if (cu_mem_read || cu_mem_write) begin
                    state_next = ST_MEM;
                end else if (cu_reg_write) begin
                    state_next = ST_WB;
                end else begin
                    pc_next    = pc_plus4;
                    retire_c   = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_active = 1'b1;
                // Read+write together behaves as a store: no writeback.
                if (dmem_ack) begin
                    if (cu_mem_write) begin
                        pc_next    = pc_plus4;
                        retire_c   = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (expired) begin
                    state_next = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_we_c   = 1'b1;
                pc_next    = pc_plus4;
                retire_c   = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALTED: state_next = ST_HALTED;
            ST_FAULT:  state_next = ST_FAULT;
            default:   state_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= ST_FETCH;
            pc_reg    <= PC_RESET;
            ir_reg    <= '0;
            cyc_reg   <= '0;
            ret_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            if ((state_reg != ST_HALTED) && (state_reg != ST_FAULT) && !(&cyc_reg)) begin
                cyc_reg <= cyc_reg + CNT_W'(1);
            end
            if (retire_c && !(&ret_reg)) begin
                ret_reg <= ret_reg + CNT_W'(1);
            end
        end
    end

    // Requests are gated by reset so they fall the moment reset asserts.
    assign imem_req  = fetch_active & arst_n;
    assign dmem_req  = mem_active & arst_n;
    assign dmem_we   = mem_active & cu_mem_write & arst_n;
    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign ir        = ir_reg;
    assign reg_we    = reg_we_c;
    assign retire    = retire_c;
    assign state     = state_reg;
    assign halted    = (state_reg == ST_HALTED);
    assign fault     = (state_reg == ST_FAULT);
    assign cyc_cnt   = cyc_reg;
    assign ret_cnt   = ret_reg;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized and directed bench for mc_sequencer against a per-instruction latency/PC model.
module tb_mc_sequencer;

    localparam logic [31:0] PCB = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, sel;
    logic        imem_ack, dmem_ack;
    logic [31:0] imem_rdata;
    logic        cu_mem_read, cu_mem_write, cu_reg_write;
    logic        cu_br_eq, cu_br_ne, cu_br_tz, alu_zero, alu_cout;

    logic        a_imem_req, a_dmem_req, a_dmem_we, a_reg_we, a_retire, a_halted, a_fault;
    logic [31:0] a_imem_addr, a_ir, a_pc, a_cyc, a_ret;
    logic [2:0]  a_state;
    logic        b_imem_req, b_dmem_req, b_dmem_we, b_reg_we, b_retire, b_halted, b_fault;
    logic [31:0] b_imem_addr, b_ir, b_pc;
    logic [3:0]  b_cyc, b_ret;
    logic [2:0]  b_state;

    logic        s_imem_req, s_dmem_req, s_dmem_we, s_reg_we, s_retire, s_halted, s_fault;
    logic [31:0] s_imem_addr, s_ir, s_pc, s_cyc, s_ret;
    logic [2:0]  s_state;

    mc_sequencer #(.XLEN(32), .PC_RESET(32'h0), .TIMEOUT(16), .CNT_W(32)) dut_a (
        .clk(clk), .arst_n(rst_a), .imem_req(a_imem_req), .imem_addr(a_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dmem_req(a_dmem_req), .dmem_we(a_dmem_we),
        .dmem_ack(dmem_ack), .cu_mem_read(cu_mem_read), .cu_mem_write(cu_mem_write),
        .cu_reg_write(cu_reg_write), .cu_br_eq(cu_br_eq), .cu_br_ne(cu_br_ne), .cu_br_tz(cu_br_tz),
        .alu_zero(alu_zero), .alu_cout(alu_cout), .ir(a_ir), .pc(a_pc), .reg_we(a_reg_we),
        .retire(a_retire), .state(a_state), .halted(a_halted), .fault(a_fault),
        .cyc_cnt(a_cyc), .ret_cnt(a_ret));

    mc_sequencer #(.XLEN(32), .PC_RESET(PCB), .TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk(clk), .arst_n(rst_b), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dmem_req(b_dmem_req), .dmem_we(b_dmem_we),
        .dmem_ack(dmem_ack), .cu_mem_read(cu_mem_read), .cu_mem_write(cu_mem_write),
        .cu_reg_write(cu_reg_write), .cu_br_eq(cu_br_eq), .cu_br_ne(cu_br_ne), .cu_br_tz(cu_br_tz),
        .alu_zero(alu_zero), .alu_cout(alu_cout), .ir(b_ir), .pc(b_pc), .reg_we(b_reg_we),
        .retire(b_retire), .state(b_state), .halted(b_halted), .fault(b_fault),
        .cyc_cnt(b_cyc), .ret_cnt(b_ret));

    always_comb begin
        s_imem_req  = sel ? b_imem_req  : a_imem_req;
        s_imem_addr = sel ? b_imem_addr : a_imem_addr;
        s_dmem_req  = sel ? b_dmem_req  : a_dmem_req;
        s_dmem_we   = sel ? b_dmem_we   : a_dmem_we;
        s_ir        = sel ? b_ir        : a_ir;
        s_pc        = sel ? b_pc        : a_pc;
        s_reg_we    = sel ? b_reg_we    : a_reg_we;
        s_retire    = sel ? b_retire    : a_retire;
        s_state     = sel ? b_state     : a_state;
        s_halted    = sel ? b_halted    : a_halted;
        s_fault     = sel ? b_fault     : a_fault;
        s_cyc       = sel ? {28'b0, b_cyc} : a_cyc;
        s_ret       = sel ? {28'b0, b_ret} : a_ret;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    longint      m_cyc, m_ret, m_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > m_max) ? m_max : v;
    endfunction

    task automatic do_reset(input logic which);
        sel = which;
        rst_a = 1'b0; rst_b = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
        {cu_mem_read, cu_mem_write, cu_reg_write, cu_br_eq, cu_br_ne, cu_br_tz} = '0;
        {alu_zero, alu_cout} = '0;
        #1 chk("rst_imem_req", 32'(s_imem_req), 32'd0);
        repeat (2) @(negedge clk);
        if (which) rst_b = 1'b1; else rst_a = 1'b1;
        m_pc  = which ? PCB : 32'h0;
        m_cyc = 0; m_ret = 0;
        m_max = which ? 64'd15 : 64'hFFFF_FFFF;
        #1;
        chk("rst_state", 32'(s_state), 32'd0);
        chk("rst_pc", s_pc, m_pc);
        chk("rst_ir", s_ir, 32'd0);
        chk("rst_cyc", s_cyc, 32'd0);
        chk("rst_ret", s_ret, 32'd0);
        chk("rst_status", 32'({s_halted, s_fault}), 32'd0);
        chk("rst_req_after", 32'({s_imem_req, s_dmem_req}), 32'd2);
    endtask

    task automatic run_instr(input logic [31:0] instr, input logic rd, input logic wr,
                             input logic rw, input logic beq, input logic bne, input logic btz,
                             input logic z, input logic co, input int di, input int dd);
        logic        isbr, taken, mem, wb, done, req_i, req_d;
        logic [31:0] npc;
        int          exp_cyc, got, nwe, we_cyc, fw, dw;
        isbr  = beq | bne | btz;
        taken = (beq && z) || (bne && !z) || (btz && !co && !z);
        mem   = !isbr && (rd || wr);
        wb    = !isbr && (mem ? !wr : rw);
        npc   = m_pc + 32'd4;
        if (isbr && taken) npc = npc + 32'(int'($signed(instr[15:0])) * 4);
        exp_cyc = (di + 1) + 2 + (mem ? dd + 1 : 0) + (wb ? 1 : 0);
        cu_mem_read = rd; cu_mem_write = wr; cu_reg_write = rw;
        cu_br_eq = beq; cu_br_ne = bne; cu_br_tz = btz; alu_zero = z; alu_cout = co;
        done = 1'b0; got = 0; nwe = 0; we_cyc = 0; fw = 0; dw = 0;
        chk("start_state", 32'(s_state), 32'd0);
        chk("start_pc", s_pc, m_pc);
        chk("start_cyc", s_cyc, 32'(m_cyc));
        chk("start_ret", s_ret, 32'(m_ret));
        for (int c = 1; c <= 100; c++) begin
            req_i = s_imem_req;
            req_d = s_dmem_req;
            if (req_i) chk("imem_addr", s_imem_addr, m_pc);
            if (req_d) chk("dmem_we", 32'(s_dmem_we), 32'(wr));
            if (c == di + 2) chk("ir", s_ir, instr);
            imem_ack   = req_i ? (fw == di) : 1'($urandom);
            imem_rdata = (req_i && fw == di) ? instr : $urandom;
            dmem_ack   = req_d ? (dw == dd) : 1'($urandom);
            if (req_i) fw++;
            if (req_d) dw++;
            #1;
            if (s_reg_we) begin
                nwe++;
                if (we_cyc == 0) we_cyc = c;
            end
            if (s_retire) begin
                done = 1'b1;
                got  = c;
            end
            @(negedge clk);
            if (done) break;
        end
        chk("retired", 32'(done), 32'd1);
        chk("cycles", 32'(got), 32'(exp_cyc));
        chk("reg_we_cnt", 32'(nwe), 32'(wb));
        chk("reg_we_cyc", 32'(we_cyc), wb ? 32'(exp_cyc) : 32'd0);
        $display("instr ir=%h pc=%h->%h cycles=%0d exp=%0d", instr, m_pc, npc, got, exp_cyc);
        m_pc  = npc;
        m_cyc = sat(m_cyc + exp_cyc);
        m_ret = sat(m_ret + 1);
    endtask

    task automatic run_rand(input int maxd);
        logic [31:0] instr;
        logic        rd, wr, rw, beq, bne, btz;
        int          k;
        k = int'($urandom_range(3, 0));
        instr = $urandom;
        if (instr[31:26] == 6'h3F) instr[26] = 1'b0;
        rd = 1'b0; wr = 1'b0; rw = 1'($urandom); {beq, bne, btz} = 3'b000;
        case (k)
            1: rd = 1'b1;
            2: begin wr = 1'b1; rd = 1'($urandom); end
            3: {beq, bne, btz} = 3'($urandom_range(7, 1));
            default: ;
        endcase
        run_instr(instr, rd, wr, rw, beq, bne, btz, 1'($urandom), 1'($urandom),
                  int'($urandom_range(maxd, 0)), int'($urandom_range(maxd, 0)));
    endtask

    task automatic run_halt;
        chk("halt_start_pc", s_pc, m_pc);
        imem_ack = 1'b1; imem_rdata = 32'hFC00_0000; dmem_ack = 1'b0;
        @(negedge clk);
        chk("halt_ir", s_ir, 32'hFC00_0000);
        chk("halt_decode", 32'(s_state), 32'd1);
        imem_ack = 1'($urandom); imem_rdata = $urandom;
        @(negedge clk);
        m_cyc = sat(m_cyc + 2);
        for (int i = 0; i < 4; i++) begin
            chk("halted", 32'({s_halted, s_fault, s_state}), 32'b10_101);
            chk("halt_quiet", 32'({s_imem_req, s_dmem_req, s_reg_we, s_retire}), 32'd0);
            chk("halt_frozen", {s_pc ^ m_pc} | {s_ir ^ 32'hFC00_0000}, 32'd0);
            chk("halt_cyc", s_cyc, 32'(m_cyc));
            chk("halt_ret", s_ret, 32'(m_ret));
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom); imem_rdata = $urandom;
            @(negedge clk);
        end
        $display("halt pc=%h cyc=%0d ret=%0d", s_pc, s_cyc, s_ret);
    endtask

    initial begin
        sel = 1'b0;
        // Unit A: TIMEOUT 16, wide counters.
        do_reset(1'b0);
        run_instr(32'h0000_0000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h1000_FFFF, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        run_instr(32'h1000_FFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_instr(32'h8C00_0000, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3);
        run_instr(32'hAC00_0000, 1, 1, 1, 0, 0, 0, 0, 0, 2, 1);
        for (int i = 0; i < 40; i++) run_rand(5);

        // Reset abandons a load waiting in MEM.
        cu_mem_read = 1'b1; cu_mem_write = 1'b0; cu_reg_write = 1'b1;
        {cu_br_eq, cu_br_ne, cu_br_tz} = 3'b000;
        imem_ack = 1'b1; imem_rdata = 32'h8C00_0010; dmem_ack = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_mem_req", 32'(s_dmem_req), 32'd1);
        #1 rst_a = 1'b0;
        #1 chk("abort_dmem_req", 32'({s_dmem_req, s_imem_req}), 32'd0);
        chk("abort_pc", s_pc, 32'h0);
        $display("reset mid-MEM pc=%h state=%0d", s_pc, s_state);
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) run_rand(5);
        run_halt();

        // Unit B: TIMEOUT 4, 4-bit counters, PC reset near wrap.
        do_reset(1'b1);
        for (int c = 1; c <= 4; c++) begin
            chk("to_wait", 32'({s_imem_req, s_fault, s_state}), 32'b10_000);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            chk("to_fault", 32'({s_fault, s_halted, s_state}), 32'b10_110);
            chk("to_quiet", 32'({s_imem_req, s_dmem_req}), 32'd0);
            chk("to_cyc", s_cyc, 32'd4);
            chk("to_pc", s_pc, PCB);
            @(negedge clk);
        end
        $display("timeout fault=%0d cyc=%0d", s_fault, s_cyc);
        do_reset(1'b1);
        run_instr(32'h8C00_0000, 1, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        for (int i = 0; i < 20; i++) run_rand(3);
        run_halt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
